// File: rtl/trap_sequencer_if.sv
// ----------------------------------------------------------------------------
// trap_sequencer_if
// Write port of the CSR register file plus the mepc read-back used by MRET.
//   csr_we     : write enable            (sequencer -> CSR file)
//   csr_addr   : 12-bit CSR write address (sequencer -> CSR file)
//   csr_wdata  : 32-bit CSR write data    (sequencer -> CSR file)
//   csr_mepc   : current mepc value       (CSR file  -> sequencer)
// ----------------------------------------------------------------------------
interface trap_sequencer_if;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_mepc;

    modport master (
        output csr_we,
        output csr_addr,
        output csr_wdata,
        input  csr_mepc
    );

    modport slave (
        input  csr_we,
        input  csr_addr,
        input  csr_wdata,
        output csr_mepc
    );
endinterface

// File: rtl/trap_sequencer.sv
// ----------------------------------------------------------------------------
// trap_sequencer
// Sequences machine-mode trap entry (mepc, mcause, mtval writes then a fetch
// redirect to the trap vector) and MRET return (redirect to mepc). Owns the
// single CSR write port, which the pipeline uses whenever no trap is running.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   XB_* / FD_*                : exception sources and PCs from XB/FD stages
//   mret                       : XB instruction is MRET
//   pipe_csr_we/addr/wdata     : pipeline CSR write request
//   csr (master modport)       : CSR file write port and mepc read-back
//   stall, flush               : pipeline hold / squash
//   redirect_valid/redirect_pc : fetch redirect
//   trap_count                 : number of accepted traps (wraps)
// ----------------------------------------------------------------------------
module trap_sequencer #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 XB_bubble,
    input  logic                 XB_exc_illegal,
    input  logic [31:0]          XB_pc,
    input  logic                 FD_exc_inst_misaligned,
    input  logic                 FD_exc_illegal,
    input  logic                 FD_exc_load_misaligned,
    input  logic                 FD_exc_store_misaligned,
    input  logic [31:0]          FD_pc,
    input  logic [31:0]          FD_badaddr,
    input  logic                 mret,
    input  logic                 pipe_csr_we,
    input  logic [11:0]          pipe_csr_addr,
    input  logic [31:0]          pipe_csr_wdata,
    trap_sequencer_if.master     csr,
    output logic                 stall,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic [CNT_W-1:0]     trap_count
);

    typedef enum logic [2:0] {
        StIdle,
        StWMepc,
        StWMcause,
        StWMtval,
        StRedirect,
        StMretRedir
    } state_e;

    state_e             r_state, w_state_next;
    logic [31:0]        r_epc, r_tval;
    logic [3:0]         r_cause;
    logic [CNT_W-1:0]   r_trap_count;

    logic               w_exc_any, w_take_exc, w_take_mret;
    logic [31:0]        w_epc, w_tval;
    logic [3:0]         w_cause;

    // Exception detection and priority-ordered capture values.
    always_comb begin
        w_exc_any   = XB_exc_illegal | FD_exc_inst_misaligned | FD_exc_illegal |
                      FD_exc_load_misaligned | FD_exc_store_misaligned;
        w_take_exc  = (r_state == StIdle) & ~XB_bubble & w_exc_any;
        w_take_mret = (r_state == StIdle) & ~XB_bubble & mret & ~w_exc_any;
        w_cause     = 4'd0;
        w_epc       = 32'h0;
        w_tval      = 32'h0;
        if (XB_exc_illegal) begin
            w_cause = 4'd2;
            w_epc   = XB_pc;
        end else if (FD_exc_inst_misaligned) begin
            w_cause = 4'd0;
            w_epc   = FD_pc;
            w_tval  = FD_badaddr;
        end else if (FD_exc_illegal) begin
            w_cause = 4'd2;
            w_epc   = FD_pc;
        end else if (FD_exc_load_misaligned) begin
            w_cause = 4'd4;
            w_epc   = FD_pc;
            w_tval  = FD_badaddr;
        end else if (FD_exc_store_misaligned) begin
            w_cause = 4'd6;
            w_epc   = FD_pc;
            w_tval  = FD_badaddr;
        end
    end

    // Next state and outputs.
    always_comb begin
        w_state_next   = r_state;
        csr.csr_we     = 1'b0;
        csr.csr_addr   = 12'h000;
        csr.csr_wdata  = 32'h0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        unique case (r_state)
            StIdle: begin
                // The older XB instruction commits unless it is the one trapping.
                if (!(w_take_exc && XB_exc_illegal)) begin
                    csr.csr_we    = pipe_csr_we;
                    csr.csr_addr  = pipe_csr_addr;
                    csr.csr_wdata = pipe_csr_wdata;
                end
                if (w_take_exc) begin
                    stall        = 1'b1;
                    flush        = 1'b1;
                    w_state_next = StWMepc;
                end else if (w_take_mret) begin
                    stall        = 1'b1;
                    flush        = 1'b1;
                    w_state_next = StMretRedir;
                end
            end
            StWMepc: begin
                stall         = 1'b1;
                csr.csr_we    = 1'b1;
                csr.csr_addr  = 12'h341;
                csr.csr_wdata = r_epc;
                w_state_next  = StWMcause;
            end
            StWMcause: begin
                stall         = 1'b1;
                csr.csr_we    = 1'b1;
                csr.csr_addr  = 12'h342;
                csr.csr_wdata = {28'h0, r_cause};
                w_state_next  = StWMtval;
            end
            StWMtval: begin
                stall         = 1'b1;
                csr.csr_we    = 1'b1;
                csr.csr_addr  = 12'h343;
                csr.csr_wdata = r_tval;
                w_state_next  = StRedirect;
            end
            StRedirect: begin
                stall          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = TRAP_VECTOR;
                w_state_next   = StIdle;
            end
            StMretRedir: begin
                stall          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = csr.csr_mepc;
                w_state_next   = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
        // Outputs are held at zero while reset is asserted.
        if (reset) begin
            csr.csr_we     = 1'b0;
            csr.csr_addr   = 12'h000;
            csr.csr_wdata  = 32'h0;
            stall          = 1'b0;
            flush          = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_epc        <= 32'h0;
            r_cause      <= 4'd0;
            r_tval       <= 32'h0;
            r_trap_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_take_exc) begin
                r_epc        <= w_epc;
                r_cause      <= w_cause;
                r_tval       <= w_tval;
                r_trap_count <= r_trap_count + 1'b1;
            end
        end
    end

    assign trap_count = reset ? '0 : r_trap_count;

endmodule

// File: tb/tb_trap_sequencer.sv
// ----------------------------------------------------------------------------
// tb_trap_sequencer
// Directed scenarios followed by randomized traffic. A reference model turns
// each cycle's inputs into the expected outputs for that cycle (scheduling the
// future trap writes/redirects into a pending list); a monitor pops the
// expectations and compares against the DUT on the falling edge.
// ----------------------------------------------------------------------------
module tb_trap_sequencer;
    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        XB_bubble, XB_exc_illegal, FD_exc_inst_misaligned, FD_exc_illegal;
    logic        FD_exc_load_misaligned, FD_exc_store_misaligned, mret;
    logic [31:0] XB_pc, FD_pc, FD_badaddr;
    logic        pipe_csr_we;
    logic [11:0] pipe_csr_addr;
    logic [31:0] pipe_csr_wdata;
    logic        stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [CNT_W-1:0] trap_count;

    trap_sequencer_if u_if ();

    trap_sequencer #(
        .TRAP_VECTOR (32'h0000_0000),
        .CNT_W       (CNT_W)
    ) u_dut (
        .clk                     (clk),
        .reset                   (reset),
        .XB_bubble               (XB_bubble),
        .XB_exc_illegal          (XB_exc_illegal),
        .XB_pc                   (XB_pc),
        .FD_exc_inst_misaligned  (FD_exc_inst_misaligned),
        .FD_exc_illegal          (FD_exc_illegal),
        .FD_exc_load_misaligned  (FD_exc_load_misaligned),
        .FD_exc_store_misaligned (FD_exc_store_misaligned),
        .FD_pc                   (FD_pc),
        .FD_badaddr              (FD_badaddr),
        .mret                    (mret),
        .pipe_csr_we             (pipe_csr_we),
        .pipe_csr_addr           (pipe_csr_addr),
        .pipe_csr_wdata          (pipe_csr_wdata),
        .csr                     (u_if.master),
        .stall                   (stall),
        .flush                   (flush),
        .redirect_valid          (redirect_valid),
        .redirect_pc             (redirect_pc),
        .trap_count              (trap_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic [3:0]  cnt;
        bit          use_mepc;
    } exp_t;

    exp_t sb_q[$];
    exp_t pend_q[$];
    int   model_cnt = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic exp_t blank();
        exp_t e;
        e.we = 0; e.addr = 0; e.wdata = 0; e.stall = 0; e.flush = 0;
        e.rv = 0; e.rpc = 0; e.cnt = 0; e.use_mepc = 0;
        return e;
    endfunction

    // Expected outputs for the inputs currently applied.
    task automatic model_eval();
        exp_t e, w;
        int   cause;
        logic [31:0] epc, tval;
        bit   exc;
        e = blank();
        if (reset) begin
            pend_q.delete();
            model_cnt = 0;
        end else if (pend_q.size() > 0) begin
            e = pend_q.pop_front();
            if (e.use_mepc) e.rpc = u_if.csr_mepc;
            e.cnt = model_cnt[3:0];
        end else begin
            e.cnt = model_cnt[3:0];
            exc = XB_exc_illegal | FD_exc_inst_misaligned | FD_exc_illegal |
                  FD_exc_load_misaligned | FD_exc_store_misaligned;
            if (!XB_bubble && exc) begin
                if (XB_exc_illegal)              begin cause = 2; epc = XB_pc; tval = 0;          end
                else if (FD_exc_inst_misaligned) begin cause = 0; epc = FD_pc; tval = FD_badaddr; end
                else if (FD_exc_illegal)         begin cause = 2; epc = FD_pc; tval = 0;          end
                else if (FD_exc_load_misaligned) begin cause = 4; epc = FD_pc; tval = FD_badaddr; end
                else                             begin cause = 6; epc = FD_pc; tval = FD_badaddr; end
                e.stall = 1; e.flush = 1;
                if (!XB_exc_illegal) begin
                    e.we = pipe_csr_we; e.addr = pipe_csr_addr; e.wdata = pipe_csr_wdata;
                end
                w = blank(); w.stall = 1; w.we = 1;
                w.addr = 12'h341; w.wdata = epc;          pend_q.push_back(w);
                w.addr = 12'h342; w.wdata = cause;        pend_q.push_back(w);
                w.addr = 12'h343; w.wdata = tval;         pend_q.push_back(w);
                w = blank(); w.stall = 1; w.rv = 1; w.rpc = 32'h0;
                pend_q.push_back(w);
                model_cnt = (model_cnt + 1) % 16;
            end else begin
                e.we = pipe_csr_we; e.addr = pipe_csr_addr; e.wdata = pipe_csr_wdata;
                if (!XB_bubble && mret) begin
                    e.stall = 1; e.flush = 1;
                    w = blank(); w.stall = 1; w.rv = 1; w.use_mepc = 1;
                    pend_q.push_back(w);
                end
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic set_idle();
        reset = 0; XB_bubble = 0; XB_exc_illegal = 0; FD_exc_inst_misaligned = 0;
        FD_exc_illegal = 0; FD_exc_load_misaligned = 0; FD_exc_store_misaligned = 0;
        mret = 0; pipe_csr_we = 0;
    endtask

    // Inputs were applied just after a rising edge; record expectation, advance.
    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: pop one expectation per cycle and compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (stall !== e.stall || flush !== e.flush || u_if.csr_we !== e.we ||
                    redirect_valid !== e.rv || redirect_pc !== e.rpc ||
                    trap_count !== e.cnt ||
                    (e.we && (u_if.csr_addr !== e.addr || u_if.csr_wdata !== e.wdata))) begin
                    n_fail++;
                    $display("FAIL cycle_out t=%0t got stall=%b flush=%b we=%b addr=%h data=%h rv=%b pc=%h cnt=%0d required stall=%b flush=%b we=%b addr=%h data=%h rv=%b pc=%h cnt=%0d",
                             $time, stall, flush, u_if.csr_we, u_if.csr_addr, u_if.csr_wdata,
                             redirect_valid, redirect_pc, trap_count, e.stall, e.flush, e.we,
                             e.addr, e.wdata, e.rv, e.rpc, e.cnt);
                end
            end
        end
    end

    initial begin
        set_idle();
        reset = 1;
        XB_pc = 0; FD_pc = 0; FD_badaddr = 0; pipe_csr_addr = 0; pipe_csr_wdata = 0;
        u_if.csr_mepc = 32'h0;
        @(posedge clk);
        #1;
        reset = 1; tick();
        reset = 1; tick();
        idle(2);

        // Load misaligned trap.
        FD_exc_load_misaligned = 1; FD_pc = 32'h100; FD_badaddr = 32'h203; tick();
        idle(5);
        // XB illegal outranks FD store misaligned; pipe write suppressed.
        XB_exc_illegal = 1; XB_pc = 32'h40; FD_exc_store_misaligned = 1;
        pipe_csr_we = 1; pipe_csr_addr = 12'h300; pipe_csr_wdata = 32'h99; tick();
        idle(5);
        // Pipe write passes through at acceptance.
        FD_exc_inst_misaligned = 1; FD_pc = 32'h204; FD_badaddr = 32'h206;
        pipe_csr_we = 1; pipe_csr_addr = 12'h340; pipe_csr_wdata = 32'h55; tick();
        idle(5);
        // MRET return.
        u_if.csr_mepc = 32'h1234; mret = 1; tick();
        idle(3);
        // MRET with exception: exception wins.
        mret = 1; FD_exc_illegal = 1; FD_pc = 32'h300; tick();
        idle(5);
        // Bubble masks everything.
        XB_bubble = 1; FD_exc_illegal = 1; mret = 1; tick();
        idle(1);
        // New exception during W_MCAUSE is ignored.
        FD_exc_store_misaligned = 1; FD_pc = 32'h500; FD_badaddr = 32'h501; tick();
        tick();
        XB_exc_illegal = 1; XB_pc = 32'h777; pipe_csr_we = 1; tick();
        idle(4);
        // Reset during W_MCAUSE.
        FD_exc_load_misaligned = 1; FD_pc = 32'h600; FD_badaddr = 32'h602; tick();
        tick();
        reset = 1; tick();
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset                   = ($urandom_range(0, 199) == 0);
            XB_bubble               = ($urandom_range(0, 3) == 0);
            XB_exc_illegal          = ($urandom_range(0, 24) == 0);
            FD_exc_inst_misaligned  = ($urandom_range(0, 24) == 0);
            FD_exc_illegal          = ($urandom_range(0, 24) == 0);
            FD_exc_load_misaligned  = ($urandom_range(0, 24) == 0);
            FD_exc_store_misaligned = ($urandom_range(0, 24) == 0);
            mret                    = ($urandom_range(0, 9) == 0);
            XB_pc                   = $urandom;
            FD_pc                   = $urandom;
            FD_badaddr              = $urandom;
            pipe_csr_we             = $urandom_range(0, 1);
            pipe_csr_addr           = 12'($urandom);
            pipe_csr_wdata          = $urandom;
            u_if.csr_mepc           = $urandom;
            tick();
        end
        idle(8);

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
